// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the two-port memory arbiter.
//                - arb_state_t : arbiter FSM states
//                - req_id_t    : identifies which requester owns a transaction
//                - LAT_CNT_W   : width of the read-latency counter (MEM_LAT<=7)
//                - STARVE_CNT_W: width of the fetch starvation counter
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    localparam int LAT_CNT_W    = 3;
    localparam int STARVE_CNT_W = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates an instruction-fetch port and a data port onto a
//                single memory with fixed read latency MEM_LAT. Data requests
//                have priority; fetch is forced through after STARVE_MAX
//                consecutive data grants made while fetch was waiting. Only
//                one transaction is in flight at a time.
//  Ports       : clk, rst_n (sync, active-low)
//                i_if_*  : fetch request (read only), o_if_* grant/read data
//                i_d_*   : data request (load/store), o_d_* grant/load data
//                o_mem_* : memory strobes, word address, write data
//                i_mem_rdata : read data, valid MEM_LAT cycles after o_mem_ren
//                o_busy  : high whenever the FSM is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,

    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,

    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,

    output logic        o_busy
);

    localparam logic [LAT_CNT_W-1:0]    LAT_LAST     = LAT_CNT_W'(MEM_LAT - 1);
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT = STARVE_CNT_W'(STARVE_MAX);

    arb_state_t                 r_state;
    arb_state_t                 w_state_next;
    req_id_t                    r_id;
    logic                       r_we;
    logic [31:0]                r_addr;
    logic [31:0]                r_wdata;
    logic [LAT_CNT_W-1:0]       r_lat_cnt;
    logic [STARVE_CNT_W-1:0]    r_starve;
    logic                       r_if_rvalid;
    logic                       r_d_rvalid;
    logic [31:0]                r_rdata;

    logic                       w_pick_if;
    logic                       w_take;
    logic                       w_capture;
    logic [31:0]                w_sel_addr;

    // Data wins ties unless fetch has already been passed over STARVE_MAX times.
    assign w_pick_if  = i_if_req && (!i_d_req || (r_starve == STARVE_LIMIT));
    assign w_sel_addr = w_pick_if ? i_if_addr : i_d_addr;

    // ------------------------------------------------------------------
    // Next-state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_capture    = 1'b0;
        o_if_gnt     = 1'b0;
        o_d_gnt      = 1'b0;
        o_mem_ren    = 1'b0;
        o_mem_wen    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_if_req || i_d_req) begin
                    w_take       = 1'b1;
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                o_if_gnt     = (r_id == REQ_IF);
                o_d_gnt      = (r_id == REQ_D);
                o_mem_ren    = !r_we;
                o_mem_wen    = r_we;
                w_state_next = r_we ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                // Last WAIT cycle is ACCESS+MEM_LAT, when read data is valid.
                if (r_lat_cnt == LAT_LAST) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_id        <= REQ_IF;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_lat_cnt   <= '0;
            r_starve    <= '0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_if_rvalid <= w_capture && (r_id == REQ_IF);
            r_d_rvalid  <= w_capture && (r_id == REQ_D);

            if (w_capture) begin
                r_rdata <= i_mem_rdata;
            end

            if (w_take) begin
                r_addr <= w_sel_addr & 32'hFFFF_FFFC;
                if (w_pick_if) begin
                    r_id     <= REQ_IF;
                    r_we     <= 1'b0;
                    r_starve <= '0;
                end else begin
                    r_id    <= REQ_D;
                    r_we    <= i_d_we;
                    r_wdata <= i_d_wdata;
                    if (i_if_req && (r_starve != STARVE_LIMIT)) begin
                        r_starve <= r_starve + 1'b1;
                    end
                end
            end

            if (r_state == ST_ACCESS) begin
                r_lat_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_if_rvalid = r_if_rvalid;
    assign o_d_rvalid  = r_d_rvalid;
    assign o_if_rdata  = r_rdata;
    assign o_d_rdata   = r_rdata;
    assign o_busy      = (r_state != ST_IDLE);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter. A main instance
//                (MEM_LAT=2, STARVE_MAX=3) runs fetch, store, contention,
//                withdrawal and reset scenarios; three extra instances with
//                MEM_LAT of 1, 4 and 7 see a memory whose read data encodes
//                the current cycle number, so captured data identifies the
//                exact capture cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic [31:0] GARBAGE = 32'h5A5A_5A5A;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] cyc = '0;

    // Sweep instances
    logic        sw_req     [3];
    logic        sw_if_gnt  [3];
    logic        sw_if_rv   [3];
    logic [31:0] sw_if_rd   [3];
    logic        sw_d_gnt   [3];
    logic        sw_d_rv    [3];
    logic [31:0] sw_d_rd    [3];
    logic [31:0] sw_maddr   [3];
    logic        sw_mren    [3];
    logic        sw_mwen    [3];
    logic [31:0] sw_mwdata  [3];
    logic        sw_busy    [3];
    logic [31:0] sw_mem_rdata;

    assign sw_mem_rdata = 32'hA500_0000 | {16'h0000, cyc[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_if_req   (if_req),
        .i_if_addr  (if_addr),
        .o_if_gnt   (if_gnt),
        .o_if_rvalid(if_rvalid),
        .o_if_rdata (if_rdata),
        .i_d_req    (d_req),
        .i_d_we     (d_we),
        .i_d_addr   (d_addr),
        .i_d_wdata  (d_wdata),
        .o_d_gnt    (d_gnt),
        .o_d_rvalid (d_rvalid),
        .o_d_rdata  (d_rdata),
        .o_mem_addr (mem_addr),
        .o_mem_ren  (mem_ren),
        .o_mem_wen  (mem_wen),
        .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata),
        .o_busy     (busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        mem_arbiter #(.MEM_LAT((g == 0) ? 1 : ((g == 1) ? 4 : 7)), .STARVE_MAX(3)) u_sw (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_if_req   (1'b0),
            .i_if_addr  (32'h0),
            .o_if_gnt   (sw_if_gnt[g]),
            .o_if_rvalid(sw_if_rv[g]),
            .o_if_rdata (sw_if_rd[g]),
            .i_d_req    (sw_req[g]),
            .i_d_we     (1'b0),
            .i_d_addr   (32'h0000_0100),
            .i_d_wdata  (32'h0),
            .o_d_gnt    (sw_d_gnt[g]),
            .o_d_rvalid (sw_d_rv[g]),
            .o_d_rdata  (sw_d_rd[g]),
            .o_mem_addr (sw_maddr[g]),
            .o_mem_ren  (sw_mren[g]),
            .o_mem_wen  (sw_mwen[g]),
            .o_mem_wdata(sw_mwdata[g]),
            .i_mem_rdata(sw_mem_rdata),
            .o_busy     (sw_busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One load through the main instance; memory returns data at ACCESS+2.
    task automatic run_load(input string tag, input bit use_if,
                            input logic [31:0] addr, input logic [31:0] data);
        if (use_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            d_req  = 1'b1;
            d_we   = 1'b0;
            d_addr = addr;
        end
        @(negedge clk);                             // ACCESS
        chk({tag, "_gnt"},       use_if ? if_gnt : d_gnt, 32'd1);
        chk({tag, "_other_gnt"}, use_if ? d_gnt : if_gnt, 32'd0);
        chk({tag, "_ren_wen"},   {mem_ren, mem_wen},      32'd2);
        chk({tag, "_maddr"},     mem_addr,                addr & 32'hFFFF_FFFC);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);                             // ACCESS+1
        chk({tag, "_wait1"}, {busy, if_rvalid, d_rvalid, mem_ren, if_gnt, d_gnt}, 32'h20);
        @(negedge clk);                             // ACCESS+2
        chk({tag, "_wait2"}, {busy, if_rvalid, d_rvalid}, 32'h4);
        mem_rdata = data;
        @(negedge clk);                             // ACCESS+3
        mem_rdata = GARBAGE;
        chk({tag, "_rvalid"}, {busy, if_rvalid, d_rvalid}, use_if ? 32'h2 : 32'h1);
        chk({tag, "_rdata"},  use_if ? if_rdata : d_rdata, data);
        @(negedge clk);
        chk({tag, "_rvalid_pulse"}, {if_rvalid, d_rvalid}, 32'h0);
    endtask

    initial begin
        logic [7:0]  seq;
        int          ng;
        logic        flag;
        logic [31:0] t0;
        logic [31:0] t_acc;
        logic [31:0] t_rv;
        logic [31:0] rv_data;
        int          lats [3];

        lats = '{1, 4, 7};
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = GARBAGE;
        for (int k = 0; k < 3; k++) sw_req[k] = 1'b0;

        // ---------------- reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctrl", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_ren, mem_wen, busy}, 32'h0);
        chk("reset_data", if_rdata | d_rdata | mem_addr | mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", {busy, if_gnt, d_gnt}, 32'h0);

        // ---------------- single fetch
        run_load("fetch", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);

        // ---------------- single store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0103; d_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("st_ctrl",  {d_gnt, if_gnt, mem_wen, mem_ren, busy}, 32'b10101);
        chk("st_addr",  mem_addr,  32'h0000_0100);
        chk("st_wdata", mem_wdata, 32'h1234_5678);
        d_req = 1'b0;
        @(negedge clk);
        chk("st_done", {busy, mem_wen, mem_ren, d_gnt}, 32'h0);
        chk("st_hold", mem_addr, 32'h0000_0100);
        flag = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (d_rvalid) flag = 1'b1;
            @(negedge clk);
        end
        chk("st_no_rvalid", flag, 32'h0);

        // ---------------- back-to-back stores every 2 cycles
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0204; d_wdata = 32'h0000_00AA;
        ng = 0; t0 = '0; t_acc = '0;
        for (int c = 0; c < 10 && ng < 2; c++) begin
            @(negedge clk);
            if (d_gnt) begin
                if (ng == 0) t0 = cyc; else t_acc = cyc;
                ng++;
            end
        end
        d_req = 1'b0; d_we = 1'b0;
        chk("st_b2b_spacing", t_acc - t0, 32'd2);
        @(negedge clk);
        @(negedge clk);

        // ---------------- contention with starvation guard
        if_req = 1'b1; if_addr = 32'h0000_0200;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        seq = '0; ng = 0; flag = 1'b0;
        for (int c = 0; c < 60 && ng < 8; c++) begin
            @(negedge clk);
            if ((if_gnt && d_gnt) || (if_rvalid && d_rvalid)) flag = 1'b1;
            if (if_gnt || d_gnt) begin
                seq = {seq[6:0], if_gnt};
                ng++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("cont_grant_count", ng, 32'd8);
        chk("cont_order",       seq, 32'h11);
        chk("cont_no_overlap",  flag, 32'h0);
        for (int c = 0; c < 5; c++) @(negedge clk);

        // ---------------- request withdrawal during fetch WAIT
        if_req = 1'b1; if_addr = 32'h0000_0020;
        @(negedge clk);
        chk("wd_if_gnt", if_gnt, 32'd1);
        if_req = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0060;
        @(negedge clk);
        d_req = 1'b0;
        mem_rdata = 32'h600D_600D;
        @(negedge clk);
        mem_rdata = GARBAGE;
        chk("wd_if_rdata", {31'h0, if_rvalid} ^ if_rdata, 32'h600D_600C);
        flag = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (d_gnt || busy) flag = 1'b1;
            @(negedge clk);
        end
        chk("wd_no_d_gnt", flag, 32'h0);

        // ---------------- reset mid-load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
        @(negedge clk);
        chk("rst_ld_gnt", d_gnt, 32'd1);
        d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_ctrl", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_ren, mem_wen, busy}, 32'h0);
        chk("rst_mid_data", if_rdata | d_rdata | mem_addr | mem_wdata, 32'h0);
        rst_n = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        flag = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mem_rdata = GARBAGE;
            if (d_rvalid || if_rvalid || busy) flag = 1'b1;
        end
        chk("rst_no_rvalid", flag, 32'h0);
        run_load("recover", 1'b0, 32'h0000_0086, 32'h1357_2468);

        // ---------------- MEM_LAT sweep
        for (int k = 0; k < 3; k++) begin
            sw_req[k] = 1'b1;
            @(negedge clk);
            t_acc = cyc;
            chk($sformatf("sweep%0d_gnt", lats[k]), sw_d_gnt[k], 32'd1);
            sw_req[k] = 1'b0;
            t_rv = '0; rv_data = '0;
            for (int c = 0; c < 15; c++) begin
                @(negedge clk);
                if (sw_d_rv[k]) begin
                    t_rv    = cyc;
                    rv_data = sw_d_rd[k];
                    break;
                end
            end
            chk($sformatf("sweep%0d_latency", lats[k]), t_rv - t_acc, 32'(lats[k] + 1));
            chk($sformatf("sweep%0d_rdata", lats[k]), rv_data,
                32'hA500_0000 | {16'h0000, 16'(t_acc + 32'(lats[k]))});
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, memory read latency in cycles from mem_ren to valid mem_rdata; legal range 1..7.
REQ-002 Parameter STARVE_MAX, default 3, consecutive data grants tolerated while fetch waits; legal range 1..15.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 if_req  in  1  fetch port request; held until if_gnt.
REQ-006 if_addr  in  32  fetch byte address; held with if_req.
REQ-007 if_gnt  out  1  one-cycle fetch grant pulse.
REQ-008 if_rvalid  out  1  one-cycle fetch read-data-valid pulse.
REQ-009 if_rdata  out  32  fetch read data; meaningful only with if_rvalid.
REQ-010 d_req  in  1  data port request; held until d_gnt.
REQ-011 d_we  in  1  data port write enable (1 = store, 0 = load); held with d_req.
REQ-012 d_addr  in  32  data byte address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_gnt  out  1  one-cycle data grant pulse.
REQ-015 d_rvalid  out  1  one-cycle load-data-valid pulse; never pulses for stores.
REQ-016 d_rdata  out  32  load data; meaningful only with d_rvalid.
REQ-017 mem_addr  out  32  shared memory word address: selected address with bits [1:0] forced to 0.
REQ-018 mem_ren  out  1  memory read strobe.
REQ-019 mem_wen  out  1  memory write strobe.
REQ-020 mem_wdata  out  32  memory write data.
REQ-021 mem_rdata  in  32  memory read data, valid exactly MEM_LAT cycles after the mem_ren cycle.
REQ-022 busy  out  1  high in every state except IDLE.

Function
REQ-023 FSM states are IDLE, ACCESS and WAIT; at most one transaction is outstanding.
REQ-024 IDLE: when any request is sampled, the arbiter picks a winner, registers its address, data and write enable, and moves to ACCESS; with no request it stays in IDLE.
REQ-025 Winner selection: data beats fetch when both request, except that fetch wins when starve_cnt == STARVE_MAX.
REQ-026 starve_cnt increments, saturating at STARVE_MAX, on each data grant made while if_req is high; it clears on every fetch grant.
REQ-027 ACCESS lasts exactly one cycle: the winner's gnt is 1, exactly one of mem_ren or mem_wen is 1, and mem_addr/mem_wdata are driven from registered values.
REQ-028 ACCESS goes to IDLE for a store and to WAIT for a load; a store therefore uses one ACCESS cycle, and back-to-back stores issue once every 2 cycles.
REQ-029 WAIT counts MEM_LAT cycles and captures mem_rdata in the cycle MEM_LAT after ACCESS.
REQ-030 The winner's rvalid/rdata are driven in the next cycle, i.e. rvalid occurs at ACCESS+MEM_LAT+1; the FSM returns to IDLE in the same cycle as rvalid.
REQ-031 Outside ACCESS, mem_ren = mem_wen = 0 and mem_addr/mem_wdata hold their last values.
REQ-032 A request arriving in ACCESS or WAIT is not sampled until the FSM returns to IDLE; there is no grant without a registered request.
REQ-033 A requester that drops req before its gnt is not granted, and no error is signalled.
REQ-034 Fetch is read-only; if_rvalid and d_rvalid are never high in the same cycle.

Reset
REQ-035 When rst_n is low at a clock edge, the FSM goes to IDLE, starve_cnt goes to 0, and every output goes to 0 (gnt, rvalid, rdata, mem_*, busy).
REQ-036 Reset in ACCESS or WAIT abandons the in-flight transaction: no rvalid is issued for it and late mem_rdata is ignored.

Structure
REQ-037 Package mem_arb_pkg holds the FSM state enum, a requester-id enum (REQ_IF, REQ_D) and the latency-counter width constant.
REQ-038 A single module is used with no sub-modules; winner selection is an inline function of the requests and starve_cnt.

Verification
REQ-039 Single fetch: if_req=1, if_addr=0x0000_0010 -> if_gnt one cycle later with mem_ren=1 and mem_addr=0x10; with mem_rdata=0xDEADBEEF at ACCESS+2, if_rvalid=1 and if_rdata=0xDEADBEEF at ACCESS+3.
REQ-040 Store: d_req=1, d_we=1, d_addr=0x0000_0103, d_wdata=0x12345678 -> one cycle with mem_wen=1, mem_addr=0x100, mem_wdata=0x12345678; d_rvalid is never asserted; busy returns to 0 the next cycle.
REQ-041 Contention: if_req and d_req held continuously with loads -> grant order D,D,D,IF,D,D,D,IF; no cycle has two grants.
REQ-042 Reset mid-load: rst_n=0 during WAIT -> all outputs 0 next cycle; no rvalid follows; the next request is served normally.
REQ-043 Request withdrawal: d_req pulsed for one cycle during a fetch WAIT -> no d_gnt is issued.
REQ-044 MEM_LAT sweep of 1, 4 and 7 -> rvalid at exactly ACCESS+MEM_LAT+1 in each case.
